// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the 8-bit pipelined CPU front end.
// Control_Unit uses the branch-select encoding; fetch uses its FSM states.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 17;

    localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 17'h0;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD
    } fetch_state_e;

    typedef enum logic [1:0] {
        BS_NONE,
        BS_ZERO,
        BS_NZERO,
        BS_ALWAYS
    } bs_sel_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a ROM word that returned while decode stalled.
// clear wins over load so a redirect always discards the parked word.
module fetch_skid_buffer #(
    parameter int DATA_W = 17,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            tag   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            tag   <= tag_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the fetch PC, drives the 1-cycle ROM, and hands decode an
// instruction register with PC history, absorbing stalls and branch redirects.
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                  PC_W      = cpu_pkg::PC_W,
    parameter int                  INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_minus_one,
    output logic [PC_W-1:0]    pc_minus_two
);

    fetch_state_e        state, state_nxt;
    logic [PC_W-1:0]     fetch_pc;
    logic [PC_W-1:0]     inflight_tag;
    logic                inflight;
    logic                issue;
    logic [PC_W-1:0]     issue_addr;
    logic                skid_load, skid_clear, skid_valid;
    logic [INSTR_W-1:0]  skid_data;
    logic [PC_W-1:0]     skid_tag;

    fetch_skid_buffer #(.DATA_W(INSTR_W), .TAG_W(PC_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_in (imem_data),
        .tag_in  (inflight_tag),
        .data    (skid_data),
        .tag     (skid_tag),
        .valid   (skid_valid)
    );

    // Issue decision is kept free of reset so the flops below never see reset
    // as data; the ROM port is gated separately.
    always_comb begin
        issue      = 1'b0;
        issue_addr = fetch_pc;
        state_nxt  = state;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect_valid) begin
            issue      = 1'b1;
            issue_addr = redirect_target;
            skid_clear = 1'b1;
            state_nxt  = S_RUN;
        end else begin
            case (state)
                S_BOOT: begin
                    issue     = 1'b1;
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    issue = !stall;
                    if (stall && inflight) begin
                        skid_load = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        issue      = 1'b1;
                        skid_clear = 1'b1;
                        state_nxt  = S_RUN;
                    end
                end
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    assign imem_rd_en = issue && !reset;
    assign imem_addr  = reset ? RESET_PC : issue_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_BOOT;
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            ir           <= NOP_INSTR;
            ir_valid     <= 1'b0;
            pc_out       <= '0;
            pc_minus_one <= '0;
            pc_minus_two <= '0;
        end else begin
            state        <= state_nxt;
            inflight     <= issue;
            inflight_tag <= issue_addr;
            if (issue)
                fetch_pc <= issue_addr + PC_W'(1);

            if (redirect_valid || !stall) begin
                pc_minus_one <= pc_out;
                pc_minus_two <= pc_minus_one;
            end

            // A bubble keeps pc_out; only the history registers advance.
            if (redirect_valid) begin
                ir       <= NOP_INSTR;
                ir_valid <= 1'b0;
            end else if (!stall) begin
                if (skid_valid) begin
                    ir       <= skid_data;
                    ir_valid <= 1'b1;
                    pc_out   <= skid_tag;
                end else if (inflight) begin
                    ir       <= imem_data;
                    ir_valid <= 1'b1;
                    pc_out   <= inflight_tag;
                end else begin
                    ir       <= NOP_INSTR;
                    ir_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for the fetch stage against a 1-cycle ROM holding ROM[a] = a + 17'h100.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'h00;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [16:0] imem_data = 17'h0;
    logic [16:0] ir;
    logic        ir_valid;
    logic [7:0]  pc_out, pc_minus_one, pc_minus_two;

    int checks = 0;
    int failures = 0;

    instruction_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_rd_en      (imem_rd_en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .pc_out          (pc_out),
        .pc_minus_one    (pc_minus_one),
        .pc_minus_two    (pc_minus_two)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_rd_en) imem_data <= 17'h100 + {9'd0, imem_addr};

    typedef struct {
        logic        stall;
        logic        redir;
        logic [7:0]  tgt;
        logic        ev;
        logic [16:0] eir;
        logic [7:0]  epc, epm1, epm2;
        logic        cpc, chist;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [7:0] t,
                                input logic ev, input logic [16:0] eir,
                                input logic [7:0] epc, input logic [7:0] e1, input logic [7:0] e2,
                                input logic cpc, input logic ch);
        vec_t v;
        v.stall = s; v.redir = r; v.tgt = t; v.ev = ev; v.eir = eir;
        v.epc = epc; v.epm1 = e1; v.epm2 = e2; v.cpc = cpc; v.chist = ch;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [16:0] eir,
                           input logic [7:0] epc);
        chk({nm, "_valid"}, {31'd0, ir_valid}, {31'd0, ev});
        chk({nm, "_ir"}, {15'd0, ir}, {15'd0, eir});
        chk({nm, "_pc"}, {24'd0, pc_out}, {24'd0, epc});
    endtask

    initial begin
        // Continuous run from reset: steady flow, stall, redirect, redirect+stall, wrap.
        vq.push_back(mk(0, 0, 8'h00, 0, 17'h000, 8'h00, 8'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h100, 8'h00, 8'h00, 8'h00, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h101, 8'h01, 8'h00, 8'h00, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h102, 8'h02, 8'h01, 8'h00, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h103, 8'h03, 8'h02, 8'h01, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h104, 8'h04, 8'h03, 8'h02, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h105, 8'h05, 8'h04, 8'h03, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 1, 17'h105, 8'h05, 8'h04, 8'h03, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 1, 17'h105, 8'h05, 8'h04, 8'h03, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 1, 17'h105, 8'h05, 8'h04, 8'h03, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h106, 8'h06, 8'h05, 8'h04, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h107, 8'h07, 8'h06, 8'h05, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h108, 8'h08, 8'h07, 8'h06, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h109, 8'h09, 8'h08, 8'h07, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h10A, 8'h0A, 8'h09, 8'h08, 1, 1));
        vq.push_back(mk(0, 1, 8'h40, 0, 17'h000, 8'h00, 8'h0A, 8'h09, 0, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h140, 8'h40, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h141, 8'h41, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h142, 8'h42, 8'h41, 8'h40, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 1, 17'h142, 8'h42, 8'h41, 8'h40, 1, 1));
        vq.push_back(mk(1, 1, 8'h80, 0, 17'h000, 8'h00, 8'h42, 8'h41, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 17'h000, 8'h00, 8'h42, 8'h41, 0, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h180, 8'h80, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h181, 8'h81, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 1, 8'hFE, 0, 17'h000, 8'h00, 8'h00, 8'h00, 0, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h1FE, 8'hFE, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h1FF, 8'hFF, 8'hFE, 8'h00, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h100, 8'h00, 8'hFF, 8'hFE, 1, 1));
        vq.push_back(mk(0, 0, 8'h00, 1, 17'h101, 8'h01, 8'h00, 8'hFF, 1, 1));

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", {15'd0, ir}, 32'd0);
        chk("rst_pc", {24'd0, pc_out}, 32'd0);
        chk("rst_pm1", {24'd0, pc_minus_one}, 32'd0);
        chk("rst_pm2", {24'd0, pc_minus_two}, 32'd0);
        chk("rst_rden", {31'd0, imem_rd_en}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);

        reset = 1'b0;
        #1;
        chk("boot_rden", {31'd0, imem_rd_en}, 32'd1);
        chk("boot_addr", {24'd0, imem_addr}, 32'd0);

        foreach (vq[i]) begin
            stall = vq[i].stall;
            redirect_valid = vq[i].redir;
            redirect_target = vq[i].tgt;
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, ir_valid}, {31'd0, vq[i].ev});
            chk($sformatf("v%0d_ir", i), {15'd0, ir}, {15'd0, vq[i].eir});
            if (vq[i].cpc)
                chk($sformatf("v%0d_pc", i), {24'd0, pc_out}, {24'd0, vq[i].epc});
            if (vq[i].chist) begin
                chk($sformatf("v%0d_pm1", i), {24'd0, pc_minus_one}, {24'd0, vq[i].epm1});
                chk($sformatf("v%0d_pm2", i), {24'd0, pc_minus_two}, {24'd0, vq[i].epm2});
            end
        end
        stall = 1'b0;
        redirect_valid = 1'b0;

        // Combinational redirect bypass, then back-to-back redirects.
        redirect_valid = 1'b1;
        redirect_target = 8'h33;
        #1;
        chk("byp_rden", {31'd0, imem_rd_en}, 32'd1);
        chk("byp_addr", {24'd0, imem_addr}, 32'h33);
        step();
        chk("b2b_0_valid", {31'd0, ir_valid}, 32'd0);
        redirect_target = 8'h55;
        step();
        chk("b2b_1_valid", {31'd0, ir_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_out("b2b_2", 1'b1, 17'h155, 8'h55);
        step();
        chk_out("b2b_3", 1'b1, 17'h156, 8'h56);

        // Reset mid-stream with the skid holding a word.
        stall = 1'b1;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 17'h000, 8'h00);
        chk("mid_rst_pm1", {24'd0, pc_minus_one}, 32'd0);
        chk("mid_rst_pm2", {24'd0, pc_minus_two}, 32'd0);
        chk("mid_rst_rden", {31'd0, imem_rd_en}, 32'd0);
        chk("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
        stall = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("mid_boot_addr", {24'd0, imem_addr}, 32'd0);
        step();
        chk("mid_0_valid", {31'd0, ir_valid}, 32'd0);
        step();
        chk_out("mid_1", 1'b1, 17'h100, 8'h00);
        step();
        chk_out("mid_2", 1'b1, 17'h101, 8'h01);

        // Redirect in the boot cycle replaces the RESET_PC fetch.
        reset = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 8'h20;
        #1;
        chk("bootr_addr", {24'd0, imem_addr}, 32'h20);
        chk("bootr_rden", {31'd0, imem_rd_en}, 32'd1);
        step();
        redirect_valid = 1'b0;
        chk("bootr_0_valid", {31'd0, ir_valid}, 32'd0);
        step();
        chk_out("bootr_1", 1'b1, 17'h120, 8'h20);
        step();
        chk_out("bootr_2", 1'b1, 17'h121, 8'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
